// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined carry-lookahead adder fed by PFA cell outputs.
//
// Stage 1 registers the per-bit PFA signals (s, p, g) and the 4-bit group P*/G*.
// Stage 2 resolves the group and bit carries and registers sum/cout (and ovf).
// A valid/ready handshake on both sides lets the ALU stall the pipe.
//
// Optional feature macro: CLA_OVF_EN adds the ovf port (signed overflow).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   pipe accepts the beat on this edge
//   a, b, cin  operands and carry-in
//   out_valid  result beat present
//   out_ready  consumer accepts the result on this edge
//   sum, cout  registered a + b + cin (mod 2^WIDTH) and carry out
//   ovf        registered signed overflow (CLA_OVF_EN only)
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned NG = WIDTH / 4;

  // Handshake
  logic v1_q, v1_d, v2_q, v2_d;
  logic adv1, adv2;

  assign adv2     = v1_q & (~v2_q | out_ready);
  assign in_ready = ~v1_q | adv2;
  assign adv1     = in_valid & in_ready;

  always_comb begin
    v1_d = v1_q;
    if (adv1)      v1_d = 1'b1;
    else if (adv2) v1_d = 1'b0;
    v2_d = v2_q;
    if (adv2)           v2_d = 1'b1;
    else if (out_ready) v2_d = 1'b0;
  end

  // PFA cells
  logic [WIDTH-1:0] s_d, p_d, g_n_d, g_d;
  logic [NG-1:0]    gp_d, gg_d;

  assign s_d   = a ^ b;
  assign p_d   = a | b;
  assign g_n_d = ~(a & b);
  assign g_d   = ~g_n_d;

  for (genvar k = 0; k < NG; k++) begin : g_grp_pg
    assign gp_d[k] = &p_d[4*k +: 4];
    assign gg_d[k] = g_d[4*k+3]
                   | (p_d[4*k+3] & g_d[4*k+2])
                   | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
                   | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
  end

  // Stage 1 state
  logic [WIDTH-1:0] s1_s_q, s1_p_q, s1_g_q;
  logic [NG-1:0]    s1_gp_q, s1_gg_q;
  logic             s1_cin_q;
`ifdef CLA_OVF_EN
  logic             s1_amsb_q, s1_bmsb_q;
`endif

  // Stage 2 carry resolution
  logic [NG:0]      c_grp;
  logic [WIDTH-1:0] c_bit;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign c_grp[0] = s1_cin_q;

  for (genvar k = 0; k < NG; k++) begin : g_carry
    assign c_grp[k+1] = s1_gg_q[k] | (s1_gp_q[k] & c_grp[k]);
    assign c_bit[4*k]   = c_grp[k];
    assign c_bit[4*k+1] = s1_g_q[4*k] | (s1_p_q[4*k] & c_grp[k]);
    assign c_bit[4*k+2] = s1_g_q[4*k+1]
                        | (s1_p_q[4*k+1] & s1_g_q[4*k])
                        | (s1_p_q[4*k+1] & s1_p_q[4*k] & c_grp[k]);
    assign c_bit[4*k+3] = s1_g_q[4*k+2]
                        | (s1_p_q[4*k+2] & s1_g_q[4*k+1])
                        | (s1_p_q[4*k+2] & s1_p_q[4*k+1] & s1_g_q[4*k])
                        | (s1_p_q[4*k+2] & s1_p_q[4*k+1] & s1_p_q[4*k] & c_grp[k]);
  end

  assign sum_d  = s1_s_q ^ c_bit;
  assign cout_d = c_grp[NG];

  // Bit 3 p/g of each group only feed P*/G*, which stage 1 already folded in.
  logic [2*NG-1:0] unused_pg_bits;
  logic            unused_pg;
  for (genvar k = 0; k < NG; k++) begin : g_unused
    assign unused_pg_bits[2*k]   = s1_p_q[4*k+3];
    assign unused_pg_bits[2*k+1] = s1_g_q[4*k+3];
  end
  assign unused_pg = ^unused_pg_bits;

  // Stage 2 state
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef CLA_OVF_EN
  logic             ovf_q, ovf_d;
  assign ovf_d = (s1_amsb_q ~^ s1_bmsb_q) & (s1_amsb_q ^ sum_d[WIDTH-1]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      s1_s_q    <= '0;
      s1_p_q    <= '0;
      s1_g_q    <= '0;
      s1_gp_q   <= '0;
      s1_gg_q   <= '0;
      s1_cin_q  <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
`ifdef CLA_OVF_EN
      s1_amsb_q <= 1'b0;
      s1_bmsb_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (adv1) begin
        s1_s_q    <= s_d;
        s1_p_q    <= p_d;
        s1_g_q    <= g_d;
        s1_gp_q   <= gp_d;
        s1_gg_q   <= gg_d;
        s1_cin_q  <= cin;
`ifdef CLA_OVF_EN
        s1_amsb_q <= a[WIDTH-1];
        s1_bmsb_q <= b[WIDTH-1];
`endif
      end
      // Output data only moves when S2 reloads; a stall holds it bit-stable.
      if (adv2) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
`ifdef CLA_OVF_EN
        ovf_q  <= ovf_d;
`endif
      end
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CLA_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe (WIDTH=16). A queue-based model tracks
// accepted beats with their age in edges; results are computed with plain
// arithmetic and compared in order as the DUT emits them.
module tb_cla_adder_pipe;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CLA_OVF_EN
  logic         ovf;
`endif

  cla_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CLA_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Model: in-flight beats in order, with expected {cout,sum}, ovf and age in edges.
  logic [W:0] exp_q[$];
  logic       ovf_q[$];
  int         age_q[$];

  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    int t;
    t = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (t > 32767) || (t < -32768);
  endfunction

  // One clock: drive, check at negedge, then update the model at the edge.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic cv, input logic rdy,
                      output logic acc);
    logic m_ir, m_ov, xf;
    rst = r; in_valid = iv; a = av; b = bv; cin = cv; out_ready = rdy;
    @(negedge clk);
    m_ir = (exp_q.size() < 2) || rdy;
    m_ov = (exp_q.size() > 0) && (age_q[0] >= 2);
    check_eq("in_ready", 32'(in_ready), 32'(m_ir));
    check_eq("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov && out_valid) begin
      check_eq("sum_cout", 32'({cout, sum}), 32'(exp_q[0]));
`ifdef CLA_OVF_EN
      check_eq("ovf", 32'(ovf), 32'(ovf_q[0]));
`endif
    end
    acc = iv && m_ir && !r;
    xf  = m_ov && rdy && !r;
    @(posedge clk);
    if (r) begin
      exp_q.delete(); ovf_q.delete(); age_q.delete();
    end else begin
      if (xf) begin
        void'(exp_q.pop_front()); void'(ovf_q.pop_front()); void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i]++;
      if (acc) begin
        exp_q.push_back(ref_sum(av, bv, cv));
        ovf_q.push_back(ref_ovf(av, bv, cv));
        age_q.push_back(1);
      end
    end
    #1;
    if (r) begin
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_sum_cout", 32'({cout, sum}), 32'd0);
`ifdef CLA_OVF_EN
      check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
    end
  endtask

  // Offer one beat until accepted, with a bounded number of tries.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input logic rdy);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      step(1'b0, 1'b1, av, bv, cv, rdy, acc);
      tries++;
    end
    if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    check_eq("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic acc;
    logic [W:0] held;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, acc);

    // Carry ripple across all groups
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    drain();
    // Signed overflow via carry-in
    send(16'h7FFF, 16'h0000, 1'b1, 1'b1);
    drain();

    // Streaming: back-to-back beats
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, W'(i), W'(16'h1000 * i), 1'(i & 1), 1'b1, acc);
      check_eq("stream_accept", 32'(acc), 32'd1);
    end
    drain();

    // Backpressure: only two of three beats fit while stalled
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, W'(16'h0100 + i), W'(16'h00F0), 1'b0, 1'b0, acc);
      check_eq("bp_accept", 32'(acc), (i < 2) ? 32'd1 : 32'd0);
    end
    held = {cout, sum};
    step(1'b0, 1'b1, 16'h0102, 16'h00F0, 1'b0, 1'b0, acc);
    check_eq("bp_hold", 32'({cout, sum}), 32'(held));
    check_eq("bp_hold_val", 32'(held), 32'(ref_sum(16'h0100, 16'h00F0, 1'b0)));
    step(1'b0, 1'b1, 16'h0102, 16'h00F0, 1'b0, 1'b1, acc);
    check_eq("bp_release_accept", 32'(acc), 32'd1);
    drain();

    // Reset mid-flight, with in_valid held high during reset
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    send(16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Random regression
    for (int i = 0; i < 10000; i++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
           1'($urandom), 1'($urandom_range(0, 1)), acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
